hex_display_scanner: RTL and testbench

Downstream consumer of the processor's 32-bit out_o. It shows the value as 8 hex digits on a time-multiplexed 7-segment display, using a common anode per digit and shared segment lines. A prescaler sets the per-digit refresh time. A shadow register holds the value and is loaded only at frame boundaries, so a frame never shows a mix of old and new digits. An optional hold freezes the display.

---
 rtl/display_pkg.sv | 16 +
 rtl/hex7seg.sv | 11 +
 rtl/hex_display_scanner.sv | 85 ++++++++
 tb/tb_hex_display_scanner.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and the hex-to-segment table for the 7-segment display scanner.
package display_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h00;

  // Active-high segments {g,f,e,d,c,b,a}, indexed by nibble value 0..F.
  localparam seg7_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-high 7-segment pattern decoder.
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 8-digit hex display driver with frame-aligned shadow loading,
// optional hold and leading-zero blanking.
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           data_i,
  input  logic [NUM_DIGITS-1:0] dp_i,
  input  logic                  hold_i,
  input  logic                  blank_lz_i,
  output logic [NUM_DIGITS-1:0] an_o,
  output seg7_t                 seg_o,
  output logic                  dp_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]      cnt;
  logic [2:0]            digit;
  logic [31:0]           shadow;
  logic [NUM_DIGITS-1:0] shadow_dp;

  logic                  tick;
  logic                  load;
  logic [31:0]           upper;
  logic                  blank;
  seg7_t                 hex_seg;
  logic [NUM_DIGITS-1:0] an_next;
  seg7_t                 seg_next;
  logic                  dp_next;

  assign tick = (cnt == CNT_MAX);
  assign load = tick && (digit == 3'd7) && !hold_i;

  // The shadow only changes as digit 7 hands over to digit 0, so a frame is never torn.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt       <= '0;
      digit     <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        digit <= digit + 3'd1;
      end
      if (load) begin
        shadow    <= data_i;
        shadow_dp <= dp_i;
      end
    end
  end

  hex7seg u_hex7seg (
    .nibble (upper[3:0]),
    .seg    (hex_seg)
  );

  // Shifting the current digit down to bit 0 makes "this nibble and all above are zero" a single test.
  always_comb begin
    upper    = shadow >> {digit, 2'b00};
    blank    = blank_lz_i && (digit != 3'd0) && (upper == 32'd0);
    an_next  = NUM_DIGITS'(1) << digit;
    seg_next = blank ? SEG_BLANK : hex_seg;
    dp_next  = !blank && shadow_dp[digit];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_o  <= {NUM_DIGITS{ACTIVE_LOW}};
      seg_o <= {7{ACTIVE_LOW}};
      dp_o  <= ACTIVE_LOW;
    end else begin
      an_o  <= an_next ^ {NUM_DIGITS{ACTIVE_LOW}};
      seg_o <= seg_next ^ {7{ACTIVE_LOW}};
      dp_o  <= dp_next ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: driver pushes model predictions, monitor pops and compares.
module tb_hex_display_scanner;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] data_i = '0;
  logic [7:0]  dp_i = '0;
  logic        hold_i = 1'b0;
  logic        blank_lz_i = 1'b0;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  hex_display_scanner #(
    .REFRESH_DIV (DIV),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .dp_i       (dp_i),
    .hold_i     (hold_i),
    .blank_lz_i (blank_lz_i),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q [$];
  int   check_count = 0;
  int   error_count = 0;

  logic [6:0] ref_seg [16];
  int         edge_count = 0;
  logic [31:0] ref_value = '0;
  logic [7:0]  ref_dp = '0;

  initial begin
    ref_seg = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  end

  // Drive one cycle of inputs and predict what the outputs become after the coming edge.
  task automatic apply_stimulus(input logic rst, input logic [31:0] data, input logic [7:0] dp,
                                input logic hold, input logic blz);
    exp_t e;
    int k, pos, nib;
    logic [31:0] above;
    logic blanked;
    @(negedge clk_i);
    rst_i = rst; data_i = data; dp_i = dp; hold_i = hold; blank_lz_i = blz;
    if (rst) begin
      e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
      edge_count = 0; ref_value = '0; ref_dp = '0;
    end else begin
      k     = edge_count + 1;
      pos   = ((k - 1) / DIV) % 8;
      above = ref_value >> (4 * pos);
      nib   = int'(above[3:0]);
      blanked = blz && (pos > 0) && (above == 0);
      e.an  = ~(8'(1) << pos);
      e.seg = blanked ? 7'h7F : ~ref_seg[nib];
      e.dp  = blanked ? 1'b1 : ~ref_dp[pos];
      if ((k % FRAME) == 0 && !hold) begin
        ref_value = data;
        ref_dp    = dp;
      end
      edge_count = k;
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input logic [31:0] data, input logic [7:0] dp,
                     input logic hold, input logic blz);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, data, dp, hold, blz);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, 32'h0, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
    check_count++;
    if (act !== req) begin
      error_count++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("an_o", an_o, e.an);
      check_output("seg_o", {1'b0, seg_o}, {1'b0, e.seg});
      check_output("dp_o", {7'b0, dp_o}, {7'b0, e.dp});
    end
  end

  initial begin
    logic [31:0] rdata;
    logic [7:0]  rdp;
    logic        rhold, rblz;
    do_reset(3);
    run(40, 32'h0, 8'h0, 1'b0, 1'b0);

    do_reset(1);
    run(48, 32'h1234ABCD, 8'h0, 1'b0, 1'b0);
    run(16, 32'hDEADBEEF, 8'h0, 1'b0, 1'b0);
    run(32, 32'h00000000, 8'h0, 1'b0, 1'b0);

    run(40, 32'h000000F0, 8'h0, 1'b0, 1'b1);
    run(32, 32'h000000F0, 8'h0, 1'b0, 1'b1);
    run(32, 32'h000000F0, 8'h0, 1'b0, 1'b0);

    run(32, 32'h00000005, 8'h0, 1'b0, 1'b0);
    run(96, 32'h00000009, 8'h0, 1'b1, 1'b0);
    run(40, 32'h00000009, 8'h0, 1'b0, 1'b0);
    run(40, 32'h00000009, 8'h01, 1'b0, 1'b0);

    do_reset(1);
    run(45, 32'h87654321, 8'hA5, 1'b0, 1'b0);
    do_reset(1);
    run(40, 32'h87654321, 8'hA5, 1'b0, 1'b0);

    rdata = '0; rdp = '0; rhold = 1'b0; rblz = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rdata = $urandom >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 7) == 0) rdp = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rhold = ~rhold;
      if ($urandom_range(0, 31) == 0) rblz = ~rblz;
      apply_stimulus(($urandom_range(0, 499) == 0), rdata, rdp, rhold, rblz);
    end

    @(negedge clk_i);
    @(negedge clk_i);
    check_output("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
